seg_debug_display: RTL and testbench

//  Board-level consumer of the pipelined processor's architectural state.

---
 rtl/seg_debug_display.sv | 119 +++++++++++
 tb/tb_seg_debug_display.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_debug_display.sv
`default_nettype none
// ============================================================================
// Module   : seg_debug_display
// Function : 4-digit multiplexed seven-segment view of the PC or a debug
//            register, snapshotted once per refresh frame so it never tears.
// Revision : 1.0
// ============================================================================
module seg_debug_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLANK       = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] dbg_reg_data,
    input  logic        sel_src,
    input  logic [4:0]  sel_reg,
    input  logic        sel_half,
    output logic [4:0]  dbg_reg_addr,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_tick
);
    localparam int            CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW:0]   BLANK_W  = (CW + 1)'(BLANK);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   snap_q, snap_d;
    logic          half_f_q, half_f_d;
    logic [4:0]    addr_q, addr_d;
    logic [3:0]    anode_q, anode_d;
    logic [6:0]    cathode_q, cathode_d;
    logic          dp_q, dp_d;
    logic          tick_q, tick_d;
    logic [31:0]   src;
    logic [3:0]    nibble;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        cnt_d    = cnt_q + CW'(1);
        idx_d    = idx_q;
        snap_d   = snap_q;
        half_f_d = half_f_q;
        tick_d   = 1'b0;
        addr_d   = sel_reg;
        src      = sel_src ? pc : dbg_reg_data;

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
            // Sources are only sampled here, so the display holds one value per frame
            if (idx_q == 2'd3) begin
                snap_d   = sel_half ? src[31:16] : src[15:0];
                half_f_d = sel_half;
                tick_d   = 1'b1;
            end
        end

        nibble    = snap_q[{idx_q, 2'b00} +: 4];
        anode_d   = ({1'b0, cnt_q} < BLANK_W) ? 4'hF : ~(4'b0001 << idx_q);
        cathode_d = hex7(nibble);
        dp_d      = ~(half_f_q && (idx_q == 2'd3));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            snap_q    <= 16'h0;
            half_f_q  <= 1'b0;
            addr_q    <= 5'd0;
            anode_q   <= 4'hF;
            cathode_q <= 7'h7F;
            dp_q      <= 1'b1;
            tick_q    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            snap_q    <= snap_d;
            half_f_q  <= half_f_d;
            addr_q    <= addr_d;
            anode_q   <= anode_d;
            cathode_q <= cathode_d;
            dp_q      <= dp_d;
            tick_q    <= tick_d;
        end
    end

    assign dbg_reg_addr = addr_q;
    assign anode        = anode_q;
    assign cathode      = cathode_q;
    assign dp           = dp_q;
    assign frame_tick   = tick_q;
endmodule
`default_nettype wire

// File: tb/tb_seg_debug_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_debug_display
// Function : Directed scoreboard bench for seg_debug_display (DIV=8, BLANK=2).
// Revision : 1.0
// ============================================================================
module tb_seg_debug_display;
    localparam int RD = 8;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = 32'h0;
    logic        sel_src = 1'b0;
    logic [4:0]  sel_reg = 5'd0;
    logic        sel_half = 1'b0;
    logic [31:0] dbg_reg_data;
    logic [4:0]  dbg_reg_addr;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int base;
    int at;
    int p;
    int cn;
    int ix;
    logic [12:0] sb_q[$];
    logic [12:0] e;

    logic [6:0] HEX [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [3:0] ANODES [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // Register-file debug port model: only r9 holds a known value
    assign dbg_reg_data = (dbg_reg_addr == 5'd9) ? 32'h0000_00F0 : 32'hEEEE_EEEE;

    seg_debug_display #(.REFRESH_DIV(RD), .BLANK(BL)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .dbg_reg_data (dbg_reg_data),
        .sel_src      (sel_src),
        .sel_reg      (sel_reg),
        .sel_half     (sel_half),
        .dbg_reg_addr (dbg_reg_addr),
        .anode        (anode),
        .cathode      (cathode),
        .dp           (dp),
        .frame_tick   (frame_tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] digit_exp(input logic [15:0] v, input logic half, input int d);
        logic [3:0] nib;
        nib = 4'((v >> (4 * d)) & 16'hF);
        return {ANODES[d], HEX[nib], ~(half && d == 3), 1'b0};
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic half);
        for (int d = 0; d < 4; d++) sb_q.push_back(digit_exp(v, half, d));
    endtask

    // base = edge count at the negedge where the frame's state sits at cnt=0, idx=0
    task automatic check_digits(input int fbase, input int first, input int last);
        logic [12:0] exp;
        for (int d = first; d <= last; d++) begin
            while (edges < fbase + 8 * d + 5) @(negedge clk);
            exp = sb_q.pop_front();
            check($sformatf("digit%0d", d), {19'h0, anode, cathode, dp, frame_tick}, {19'h0, exp});
        end
    endtask

    task automatic wait_tick(output int fbase);
        fbase = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                fbase = edges;
                break;
            end
        end
        if (fbase < 0) begin
            total++;
            bad++;
            $error("FAIL tick_timeout: observed=no frame_tick expected=frame_tick within 100 cycles");
            fbase = edges;
        end
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_anode", 32'(anode), 32'hF);
        check("rst_cathode", 32'(cathode), 32'h7F);
        check("rst_dp", 32'(dp), 32'h1);
        check("rst_tick", 32'(frame_tick), 32'h0);
        check("rst_addr", 32'(dbg_reg_addr), 32'h0);

        // Reset pulse during digit 2
        reset = 1'b0;
        base  = edges;
        while (edges < base + 21) @(negedge clk);
        check("pre_rst_anode", 32'(anode), 32'hB);
        #1 reset = 1'b1;
        #1;
        check("async_anode", 32'(anode), 32'hF);
        check("async_cathode", 32'(cathode), 32'h7F);
        check("async_dp", 32'(dp), 32'h1);
        @(negedge clk);
        sel_src  = 1'b1;
        sel_half = 1'b0;
        pc       = 32'h0040_1234;
        reset    = 1'b0;
        base     = edges;

        // Before the first snapshot the display reads 0000
        push_frame(16'h0000, 1'b0);
        check_digits(base, 0, 3);
        at = base;
        wait_tick(base);
        check("first_tick_edges", 32'(base - at), 32'd32);

        // PC low half
        push_frame(16'h1234, 1'b0);
        check_digits(base, 0, 3);
        pc       = 32'hABCD_0000;
        sel_half = 1'b1;

        // PC high half, decimal point on digit 3
        wait_tick(base);
        push_frame(16'hABCD, 1'b1);
        check_digits(base, 0, 3);

        // Register r9 through the debug port
        sel_src  = 1'b0;
        sel_half = 1'b0;
        sel_reg  = 5'd9;
        check("addr_before", 32'(dbg_reg_addr), 32'd0);
        @(posedge clk);
        #1 check("addr_after", 32'(dbg_reg_addr), 32'd9);
        wait_tick(base);
        push_frame(16'h00F0, 1'b0);
        check_digits(base, 0, 0);

        // Mid-frame change at cnt=3, idx=1 must not disturb this frame
        while (edges < base + 11) @(negedge clk);
        pc       = 32'h1357_5678;
        sel_src  = 1'b1;
        sel_half = 1'b1;
        check_digits(base, 1, 3);
        wait_tick(base);
        push_frame(16'h1357, 1'b1);
        check_digits(base, 0, 3);

        // Free run of three frames, checked every cycle
        wait_tick(base);
        for (int c = 1; c <= 96; c++) begin
            p  = (c - 1) % 32;
            cn = p % 8;
            ix = p / 8;
            e  = digit_exp(16'h1357, 1'b1, ix);
            if (cn < BL) e[12:9] = 4'hF;
            e[0] = (p == 31);
            sb_q.push_back(e);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("run_c%0d", c), {19'h0, anode, cathode, dp, frame_tick}, {19'h0, e});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
